// File: rtl/mips_reg_file_if.sv
// Register file access bundle: decoder read addresses, WB write-back,
// debug read address and the registered operand / debug outputs.
interface mips_reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              rd_en;
  logic              flush;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output rs_addr, rt_addr, rd_en, flush,
    output wr_en, wr_addr, wr_data, dbg_addr,
    input  rs_data, rt_data, dbg_data
  );

  modport slave (
    input  rs_addr, rt_addr, rd_en, flush,
    input  wr_en, wr_addr, wr_data, dbg_addr,
    output rs_data, rt_data, dbg_data
  );
endinterface

// File: rtl/mips_reg_file.sv
// 32x32 MIPS GPR bank with r0 hardwired to zero, WB write-through
// bypass, registered operand outputs and a registered debug port.
module mips_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input logic            clk,
  input logic            rst_n,
  mips_reg_file_if.slave bus
);

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic [DATA_W-1:0] rs_byp;
  logic [DATA_W-1:0] rt_byp;
  logic [DATA_W-1:0] dbg_byp;
  logic              wr_ok;

  assign wr_ok = bus.wr_en && (bus.wr_addr != '0);

  // Bypassed reads: r0 forced to zero, same-cycle WB write forwarded.
  always_comb begin
    rs_byp  = mem[bus.rs_addr];
    rt_byp  = mem[bus.rt_addr];
    dbg_byp = mem[bus.dbg_addr];
    if (wr_ok && bus.wr_addr == bus.rs_addr)
      rs_byp = bus.wr_data;
    if (wr_ok && bus.wr_addr == bus.rt_addr)
      rt_byp = bus.wr_data;
    if (wr_ok && bus.wr_addr == bus.dbg_addr)
      dbg_byp = bus.wr_data;
    if (bus.rs_addr == '0)
      rs_byp = '0;
    if (bus.rt_addr == '0)
      rt_byp = '0;
    if (bus.dbg_addr == '0)
      dbg_byp = '0;
  end

  // Write-back port; never gated by stall or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem[i] <= '0;
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Operand capture: flush beats capture, otherwise hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rs_data <= '0;
      bus.rt_data <= '0;
    end else if (bus.flush) begin
      bus.rs_data <= '0;
      bus.rt_data <= '0;
    end else if (bus.rd_en) begin
      bus.rs_data <= rs_byp;
      bus.rt_data <= rt_byp;
    end
  end

  // Debug read every cycle, independent of pipeline control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.dbg_data <= '0;
    else
      bus.dbg_data <= dbg_byp;
  end

endmodule

// File: tb/tb_mips_reg_file.sv
// Directed self-checking bench for mips_reg_file.
// Inputs change 1ns after the rising edge; outputs checked there too.
module tb_mips_reg_file;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mips_reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  mips_reg_file #(
    .DATA_W(32), .ADDR_W(5), .NUM_REGS(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rs_addr  = '0;
    bus.rt_addr  = '0;
    bus.rd_en    = 1'b0;
    bus.flush    = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.dbg_addr = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    idle();
    rst_n = 1'b0;
    #3;
    checks++;
    if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0
        || bus.dbg_data !== 32'h0) begin
      errors++;
      $display("FAIL por_outputs rs=%h rt=%h dbg=%h want 0",
               bus.rs_data, bus.rt_data, bus.dbg_data);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k < 32; k++) begin
      v = 32'h1000 + 32'(k);
      wr(5'(k), v);
    end
    bus.rs_addr  = 5'd5;
    bus.rt_addr  = 5'd31;
    bus.dbg_addr = 5'd31;
    bus.rd_en    = 1'b1;
    tick();
    checks++;
    if (bus.rs_data !== 32'h1005 || bus.rt_data !== 32'h101f
        || bus.dbg_data !== 32'h101f) begin
      errors++;
      $display("FAIL preload rs=%h rt=%h dbg=%h want 1005/101f/101f",
               bus.rs_data, bus.rt_data, bus.dbg_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0
        || bus.dbg_data !== 32'h0) begin
      errors++;
      $display("FAIL async_reset rs=%h rt=%h dbg=%h want 0",
               bus.rs_data, bus.rt_data, bus.dbg_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0
        || bus.dbg_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem r5=%h r31=%h dbg=%h want 0",
               bus.rs_data, bus.rt_data, bus.dbg_data);
    end
    idle();
  endtask

  task automatic test_r0();
    idle();
    bus.rd_en = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd0;
    bus.wr_data = 32'hDEADBEEF;
    tick();
    checks++;
    if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0
        || bus.dbg_data !== 32'h0) begin
      errors++;
      $display("FAIL r0_bypass rs=%h rt=%h dbg=%h want 0",
               bus.rs_data, bus.rt_data, bus.dbg_data);
    end
    bus.wr_en = 1'b0;
    tick();
    checks++;
    if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0
        || bus.dbg_data !== 32'h0) begin
      errors++;
      $display("FAIL r0_read rs=%h rt=%h dbg=%h want 0",
               bus.rs_data, bus.rt_data, bus.dbg_data);
    end
    idle();
  endtask

  task automatic test_write_read();
    idle();
    wr(5'd8, 32'h12345678);
    bus.rs_addr = 5'd8;
    bus.rt_addr = 5'd8;
    bus.rd_en   = 1'b1;
    tick();
    checks++;
    if (bus.rs_data !== 32'h12345678 || bus.rt_data !== 32'h12345678) begin
      errors++;
      $display("FAIL write_read rs=%h rt=%h want 12345678",
               bus.rs_data, bus.rt_data);
    end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    bus.rs_addr  = 5'd8;
    bus.rt_addr  = 5'd9;
    bus.dbg_addr = 5'd9;
    bus.rd_en    = 1'b1;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd9;
    bus.wr_data  = 32'hA5A5A5A5;
    tick();
    checks++;
    if (bus.rt_data !== 32'hA5A5A5A5 || bus.dbg_data !== 32'hA5A5A5A5
        || bus.rs_data !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass rs=%h rt=%h dbg=%h want 12345678/a5a5a5a5",
               bus.rs_data, bus.rt_data, bus.dbg_data);
    end
    bus.wr_en = 1'b0;
    tick();
    checks++;
    if (bus.rt_data !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bypass_commit rt=%h want a5a5a5a5", bus.rt_data);
    end
    idle();
  endtask

  task automatic test_stall_flush();
    idle();
    wr(5'd1, 32'h11);
    bus.rs_addr = 5'd1;
    bus.rt_addr = 5'd1;
    bus.rd_en   = 1'b1;
    tick();
    checks++;
    if (bus.rs_data !== 32'h11 || bus.rt_data !== 32'h11) begin
      errors++;
      $display("FAIL capture rs=%h rt=%h want 11", bus.rs_data, bus.rt_data);
    end
    bus.rd_en = 1'b0;
    wr(5'd1, 32'h22);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.rs_data !== 32'h11 || bus.rt_data !== 32'h11) begin
        errors++;
        $display("FAIL stall_%0d rs=%h rt=%h want 11",
                 i, bus.rs_data, bus.rt_data);
      end
      if (i < 2) tick();
    end
    bus.rd_en   = 1'b1;
    bus.flush   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd2;
    bus.wr_data = 32'h33;
    tick();
    bus.wr_en = 1'b0;
    checks++;
    if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0) begin
      errors++;
      $display("FAIL flush rs=%h rt=%h want 0", bus.rs_data, bus.rt_data);
    end
    bus.flush   = 1'b0;
    bus.rt_addr = 5'd2;
    tick();
    checks++;
    if (bus.rs_data !== 32'h22 || bus.rt_data !== 32'h33) begin
      errors++;
      $display("FAIL post_flush rs=%h rt=%h want 22/33",
               bus.rs_data, bus.rt_data);
    end
    idle();
  endtask

  task automatic test_debug_dump();
    logic [31:0] exp;
    idle();
    for (int k = 1; k < 32; k++) begin
      exp = 32'(k) * 32'd4;
      wr(5'(k), exp);
    end
    for (int k = 0; k < 32; k++) begin
      bus.dbg_addr = 5'(k);
      bus.rd_en    = k[0];
      bus.flush    = k[1];
      tick();
      exp = 32'(k) * 32'd4;
      checks++;
      if (bus.dbg_data !== exp) begin
        errors++;
        $display("FAIL dbg_r%0d got=%h want=%h", k, bus.dbg_data, exp);
      end
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_r0();
    test_write_read();
    test_bypass();
    test_stall_flush();
    test_debug_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_reg_file.md
Name: mips_reg_file

Overview:
- 32 x 32-bit MIPS general-purpose register bank in the ID stage.
- Consumes the rs/rt read addresses produced by the instruction field decoder.
- Accepts the write-back from the WB stage.
- Presents registered operands to the ID/EX boundary, and provides a registered debug read port for the debug unit to dump architectural state.

Parameters:
DATA_W, 32, register and data width in bits
ADDR_W, 5, register address width
NUM_REGS, 32, number of registers (2**ADDR_W)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rs_addr  input  ADDR_W  read port A address (instr[25:21] from decoder)
rt_addr  input  ADDR_W  read port B address (instr[20:16] from decoder)
rd_en  input  1  operand capture enable; 0 = pipeline stall, hold outputs
flush  input  1  synchronous bubble insert; clears operand outputs
wr_en  input  1  write-back strobe from WB stage
wr_addr  input  ADDR_W  write-back destination register
wr_data  input  DATA_W  write-back data
dbg_addr  input  ADDR_W  debug read address
rs_data  output  DATA_W  registered operand A
rt_data  output  DATA_W  registered operand B
dbg_data  output  DATA_W  registered debug read data

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All NUM_REGS entries clear to 0.
  - rs_data, rt_data and dbg_data clear to 0.
  - Reset takes effect immediately regardless of clk, and overrides any in-flight write or capture.
- Register 0 is hardwired to zero:
  - Writes with wr_addr=0 are discarded.
  - Any read of address 0 (A, B or debug) returns 0, including under bypass.
- Write: on a rising edge with wr_en=1 and wr_addr!=0, mem[wr_addr] <= wr_data.
- Operand capture, on each rising edge, in priority order:
  - flush=1: rs_data <= 0 and rt_data <= 0. Flush wins over rd_en.
  - else rd_en=1: rs_data <= rd(rs_addr) and rt_data <= rd(rt_addr).
  - else: hold the previous rs_data/rt_data (stall).
- rd(a), the bypassed read:
  - If a==0: 0.
  - Else if wr_en=1 and wr_addr==a: wr_data (same-cycle write-through, which removes the WB->ID hazard).
  - Else: mem[a].
- Latency:
  - Operands are visible on rs_data/rt_data one clock after the address is applied.
  - A value written at edge N is visible in a capture at edge N, through the bypass.
- Debug port:
  - dbg_data <= rd(dbg_addr) every rising edge, independent of rd_en and flush.
  - Uses the same bypass rule; one-cycle latency.
- Simultaneous events:
  - rs_addr==rt_addr: both outputs receive the same value.
  - Write and stall in the same cycle: the write still commits to mem; held outputs do not change.
  - Flush and write in the same cycle: the write commits; outputs go to 0.
- Write-back is never gated by rd_en or flush.
- Address width rule: addresses are ADDR_W bits and NUM_REGS=2**ADDR_W, so no out-of-range case exists.
- Reset is asserted asynchronously and must be released synchronously to clk by the system reset logic.

Test Plan:
- Reset: load regs 1..31 with distinct values, assert rst_n=0 mid-cycle -> all outputs 0 immediately; after release, read r5 and r31 -> 0.
- r0 protection: wr_en=1, wr_addr=0, wr_data=32'hDEADBEEF; next cycle rs_addr=0, rt_addr=0, dbg_addr=0 -> all read 0.
- Write then read: write r8=32'h12345678 at edge N; rs_addr=8, rd_en=1 at edge N+1 -> rs_data=32'h12345678 after edge N+1.
- Bypass: same cycle wr_en=1, wr_addr=9, wr_data=32'hA5A5A5A5, rt_addr=9, rd_en=1 -> rt_data=32'hA5A5A5A5 after that edge, although mem[9] held 0 before it.
- Stall/flush:
  - rs_data=32'h11 captured; rd_en=0 for 3 cycles while r1 is rewritten to 32'h22 -> rs_data stays 32'h11.
  - Raise rd_en with flush=1 -> rs_data=0.
  - Next edge with flush=0 -> rs_data=32'h22.
- Debug dump: write rk=k*4 for k=1..31; sweep dbg_addr 0..31 -> dbg_data equals k*4 one cycle later (0 for k=0), unaffected by concurrent stalls and flushes.
